// File: rtl/im_expansion.sv
// im_expansion: nearest-neighbour upscaler, replicates each source pixel into a 2^pSCALE_LOG2 square block
module im_expansion #(
    parameter int pIN_IM_WIDTH  = 160,
    parameter int pIN_IM_HEIGHT = 120,
    parameter int pSCALE_LOG2   = 2,
    parameter int pDATA_W       = 24,
    localparam int lpOUT_IM_WIDTH     = pIN_IM_WIDTH << pSCALE_LOG2,
    localparam int lpOUT_IM_HEIGHT    = pIN_IM_HEIGHT << pSCALE_LOG2,
    localparam int lpC2_IN_BYTES_NUM  = $clog2(pIN_IM_WIDTH * pIN_IM_HEIGHT),
    localparam int lpC2_OUT_BYTES_NUM = $clog2(lpOUT_IM_WIDTH * lpOUT_IM_HEIGHT)
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic [pDATA_W-1:0]            idata_rd,
    output logic [lpC2_IN_BYTES_NUM-1:0]  oaddr_rd,
    output logic                          omem_rd_en,
    output logic [pDATA_W-1:0]            odata_wr,
    output logic [lpC2_OUT_BYTES_NUM-1:0] oaddr_wr,
    output logic                          omem_wr_en,
    input  logic                          iwr_ready,
    input  logic [lpC2_IN_BYTES_NUM-1:0]  isrc_start_ptr,
    input  logic [lpC2_OUT_BYTES_NUM-1:0] idst_start_ptr,
    input  logic                          istart_work,
    output logic                          omodule_work_f,
    output logic                          omodule_done_f
);
    localparam int lpSX_W = (pIN_IM_WIDTH > 1) ? $clog2(pIN_IM_WIDTH) : 1;
    localparam int lpSY_W = (pIN_IM_HEIGHT > 1) ? $clog2(pIN_IM_HEIGHT) : 1;

    typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

    state_t                        state_q, state_d;
    logic [lpSX_W-1:0]             src_x_q, src_x_d;
    logic [lpSY_W-1:0]             src_y_q, src_y_d;
    logic [pSCALE_LOG2-1:0]        sub_x_q, sub_x_d;
    logic [pSCALE_LOG2-1:0]        sub_y_q, sub_y_d;
    logic [lpC2_IN_BYTES_NUM-1:0]  src_row_base_q, src_row_base_d;
    logic [lpC2_OUT_BYTES_NUM-1:0] dst_ptr_q, dst_ptr_d;
    logic [pDATA_W-1:0]            pixel_q, pixel_d;

    assign oaddr_rd = src_row_base_q + lpC2_IN_BYTES_NUM'(src_x_q);
    assign oaddr_wr = dst_ptr_q;
    assign odata_wr = pixel_q;

    // next-state, counter advance and strobe decode; a source row is re-read once per output sub-row
    always_comb begin
        state_d        = state_q;
        src_x_d        = src_x_q;
        src_y_d        = src_y_q;
        sub_x_d        = sub_x_q;
        sub_y_d        = sub_y_q;
        src_row_base_d = src_row_base_q;
        dst_ptr_d      = dst_ptr_q;
        pixel_d        = pixel_q;
        omem_rd_en     = 1'b0;
        omem_wr_en     = 1'b0;
        omodule_work_f = 1'b0;
        omodule_done_f = 1'b0;
        case (state_q)
            IDLE: begin
                if (istart_work) begin
                    src_row_base_d = isrc_start_ptr;
                    dst_ptr_d      = idst_start_ptr;
                    src_x_d        = '0;
                    src_y_d        = '0;
                    sub_x_d        = '0;
                    sub_y_d        = '0;
                    state_d        = RD;
                end
            end
            RD: begin
                omem_rd_en     = 1'b1;
                omodule_work_f = 1'b1;
                state_d        = LAT;
            end
            LAT: begin
                omodule_work_f = 1'b1;
                pixel_d        = idata_rd;
                state_d        = WR;
            end
            WR: begin
                omodule_work_f = 1'b1;
                omem_wr_en     = 1'b1;
                if (iwr_ready) begin
                    dst_ptr_d = dst_ptr_q + 1'b1;
                    sub_x_d   = sub_x_q + 1'b1;
                    if (&sub_x_q) begin
                        state_d = RD;
                        if (src_x_q != lpSX_W'(pIN_IM_WIDTH - 1)) begin
                            src_x_d = src_x_q + 1'b1;
                        end else begin
                            src_x_d = '0;
                            sub_y_d = sub_y_q + 1'b1;
                            if (&sub_y_q) begin
                                src_y_d        = src_y_q + 1'b1;
                                src_row_base_d = src_row_base_q + lpC2_IN_BYTES_NUM'(pIN_IM_WIDTH);
                                state_d        = (src_y_q == lpSY_W'(pIN_IM_HEIGHT - 1)) ? DONE : RD;
                            end
                        end
                    end
                end
            end
            DONE: begin
                omodule_done_f = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and counter registers; reset abandons any frame in flight
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q        <= IDLE;
            src_x_q        <= '0;
            src_y_q        <= '0;
            sub_x_q        <= '0;
            sub_y_q        <= '0;
            src_row_base_q <= '0;
            dst_ptr_q      <= '0;
            pixel_q        <= '0;
        end else begin
            state_q        <= state_d;
            src_x_q        <= src_x_d;
            src_y_q        <= src_y_d;
            sub_x_q        <= sub_x_d;
            sub_y_q        <= sub_y_d;
            src_row_base_q <= src_row_base_d;
            dst_ptr_q      <= dst_ptr_d;
            pixel_q        <= pixel_d;
        end
    end
endmodule
